// File: rtl/if_id_pipe.sv
// IF/ID pipeline stage register: valid/ready handshake on both sides,
// stall/flush control, NOP bubble injection, an optional skid entry that
// makes the fetch-side ready a registered signal, and a saturating flush counter.
module if_id_pipe #(
  parameter int unsigned       XLEN   = 32,
  parameter int unsigned       INST_W = 32,
  parameter logic [INST_W-1:0] NOP    = 32'h00000013,
  parameter int unsigned       SKID   = 1,
  parameter int unsigned       CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              flush,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [XLEN-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [XLEN-1:0]   main_pc_q,    main_pc_d;
  logic [INST_W-1:0] main_inst_q,  main_inst_d;
  logic              skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]   skid_pc_q,    skid_pc_d;
  logic [INST_W-1:0] skid_inst_q,  skid_inst_d;
  logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;

  logic accept;
  logic advance;

  // Fetch-side ready: registered skid occupancy, or combinational from decode without skid
  always_comb begin
    if (SKID != 0) begin
      if_ready = ~skid_valid_q;
    end else begin
      if_ready = id_ready | ~main_valid_q;
    end
  end

  // Handshake qualifiers and next-state for main register, skid entry and counter
  always_comb begin
    accept       = if_valid & if_ready;
    advance      = main_valid_q & id_ready;
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_inst_d  = main_inst_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    flush_cnt_d  = flush_cnt_q;

    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    if (flush) begin
      main_valid_d = 1'b0;
      main_pc_d    = '0;
      main_inst_d  = NOP;
      skid_valid_d = 1'b0;
      skid_pc_d    = '0;
      skid_inst_d  = NOP;
    end else if (SKID != 0) begin
      if (!main_valid_q || advance) begin
        // Skid beat is older than the input beat, so it drains first
        if (skid_valid_q) begin
          main_valid_d = 1'b1;
          main_pc_d    = skid_pc_q;
          main_inst_d  = skid_inst_q;
          skid_valid_d = 1'b0;
          skid_pc_d    = '0;
          skid_inst_d  = NOP;
        end else if (accept) begin
          main_valid_d = 1'b1;
          main_pc_d    = if_pc;
          main_inst_d  = if_inst;
        end else begin
          main_valid_d = 1'b0;
          main_pc_d    = '0;
          main_inst_d  = NOP;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = if_pc;
        skid_inst_d  = if_inst;
      end
    end else begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_pc_d    = if_pc;
        main_inst_d  = if_inst;
      end else if (advance) begin
        main_valid_d = 1'b0;
        main_pc_d    = '0;
        main_inst_d  = NOP;
      end
    end
  end

  // State registers with asynchronous reset to the empty/NOP state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= '0;
      main_inst_q  <= NOP;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= NOP;
      flush_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_inst_q  <= main_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Outputs come straight from the main register
  always_comb begin
    id_valid  = main_valid_q;
    id_pc     = main_pc_q;
    id_inst   = main_inst_q;
    flush_cnt = flush_cnt_q;
  end

endmodule
